// File: rtl/print_paddle_pkg.sv
// ---------------------------------------------------------------------------
// print_paddle_pkg
// Shared definitions for the paddle renderer: the stepper state encoding and
// the default screen / paddle geometry used as parameter defaults.
// ---------------------------------------------------------------------------
package print_paddle_pkg;

  // Stepper state: waiting for a command, waiting for the first frame
  // boundary after a command, or stepping once per frame toward the target.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_MOVING  = 2'd2
  } paddle_state_e;

  localparam int SCREEN_H_DEF = 480;
  localparam int BAR_W_DEF    = 10;
  localparam int BAR_H_DEF    = 90;
  localparam int STEP_DEF     = 4;
  localparam int X_POS_DEF    = 10;
  localparam int Y_INIT_DEF   = 195;

endpackage

// File: rtl/paddle_stepper.sv
// ---------------------------------------------------------------------------
// paddle_stepper
// Holds the requested paddle row, clamps it to the screen, and walks the
// paddle top row toward it by at most STEP pixels per frame boundary.
// Ports:
//   clk_i       - clock, rising edge
//   rst_i       - asynchronous active-high reset
//   cmd_valid_i - a new target row is offered this cycle
//   cmd_y_i     - requested top row (clamped internally)
//   frame_end_i - one-cycle pulse at the end of each frame
//   y_o         - current paddle top row (changes only on frame_end_i)
//   busy_o      - high while a move is pending or in progress
// ---------------------------------------------------------------------------
module paddle_stepper
  import print_paddle_pkg::*;
#(
  parameter int Y_INIT   = Y_INIT_DEF,
  parameter int BAR_H    = BAR_H_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int STEP     = STEP_DEF,
  parameter int YW       = 9
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  input  logic [YW-1:0] cmd_y_i,
  input  logic          frame_end_i,
  output logic [YW-1:0] y_o,
  output logic          busy_o
);

  // Clamp and step arithmetic use one extra bit so nothing wraps.
  localparam logic [YW:0]   Y_MAX  = (YW+1)'(SCREEN_H - BAR_H);
  localparam logic [YW:0]   STEP_W = (YW+1)'(STEP);
  localparam logic [YW-1:0] Y_RST  = YW'(Y_INIT);

  paddle_state_e state_q;
  logic [YW-1:0] y_q;
  logic [YW-1:0] target_q;
  logic [YW-1:0] y_d;

  logic [YW:0]   cmd_ext_s;
  logic [YW-1:0] cmd_clamped_s;
  logic [YW:0]   tgt_ext_s;
  logic [YW:0]   cur_ext_s;
  logic [YW:0]   dist_s;
  logic [YW:0]   step_ext_s;
  logic          up_s;
  logic          arrive_s;

  // Limit the requested row so the whole paddle stays on screen.
  always_comb begin
    cmd_ext_s     = {1'b0, cmd_y_i};
    cmd_clamped_s = cmd_y_i;
    if (cmd_ext_s > Y_MAX) begin
      cmd_clamped_s = Y_MAX[YW-1:0];
    end else begin
      cmd_clamped_s = cmd_ext_s[YW-1:0];
    end
  end

  // Next row for a frame step; always uses the stored target, so a command
  // landing on the same cycle as frame_end only affects later frames.
  always_comb begin
    tgt_ext_s  = {1'b0, target_q};
    cur_ext_s  = {1'b0, y_q};
    up_s       = 1'b0;
    dist_s     = '0;
    step_ext_s = cur_ext_s;
    if (tgt_ext_s >= cur_ext_s) begin
      up_s   = 1'b1;
      dist_s = tgt_ext_s - cur_ext_s;
    end else begin
      up_s   = 1'b0;
      dist_s = cur_ext_s - tgt_ext_s;
    end
    arrive_s = (dist_s <= STEP_W);
    if (arrive_s) begin
      step_ext_s = tgt_ext_s;
    end else if (up_s) begin
      step_ext_s = cur_ext_s + STEP_W;
    end else begin
      step_ext_s = cur_ext_s - STEP_W;
    end
    y_d = step_ext_s[YW-1:0];
  end

  // Move FSM: target capture, frame-synchronous stepping, arrival detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      y_q      <= Y_RST;
      target_q <= Y_RST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i && (cmd_clamped_s != y_q)) begin
            target_q <= cmd_clamped_s;
            state_q  <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (cmd_valid_i) begin
            target_q <= cmd_clamped_s;
          end
          // The first frame boundary only starts the move.
          if (frame_end_i) begin
            state_q <= ST_MOVING;
          end
        end
        ST_MOVING: begin
          if (cmd_valid_i) begin
            target_q <= cmd_clamped_s;
          end
          if (frame_end_i) begin
            y_q <= y_d;
            if (arrive_s) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign y_o    = y_q;
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/print_paddle.sv
// ---------------------------------------------------------------------------
// print_paddle
// Draws a vertical paddle at a fixed column whose top row follows commands
// from the custom-instruction interface, moving at most STEP rows per frame.
// Ports:
//   clk_in     - clock, rising edge
//   i_rst      - asynchronous active-high reset
//   clk_en     - command strobe
//   refreshBar - with clk_en, requests a new target row (coordY)
//   coordY     - requested paddle top row
//   frame_end  - one-cycle pulse after the last active pixel of a frame
//   o_active   - current pixel lies in the active area
//   o_x, o_y   - current pixel column / row
//   y_Atual    - current paddle top row
//   busy       - a move is pending or in progress
//   color      - registered "pixel is on the paddle" flag (1 cycle latency)
// ---------------------------------------------------------------------------
module print_paddle
  import print_paddle_pkg::*;
#(
  parameter int X_POS    = X_POS_DEF,
  parameter int Y_INIT   = Y_INIT_DEF,
  parameter int BAR_W    = BAR_W_DEF,
  parameter int BAR_H    = BAR_H_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int STEP     = STEP_DEF,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic          clk_in,
  input  logic          i_rst,
  input  logic          clk_en,
  input  logic          refreshBar,
  input  logic [YW-1:0] coordY,
  input  logic          frame_end,
  input  logic          o_active,
  input  logic [XW-1:0] o_x,
  input  logic [YW-1:0] o_y,
  output logic [YW-1:0] y_Atual,
  output logic          busy,
  output logic          color
);

  // Pixel bounds in two extra bits so the bottom/right edges cannot wrap.
  localparam logic [XW+1:0] X_LO    = (XW+2)'(X_POS);
  localparam logic [XW+1:0] X_HI    = (XW+2)'(X_POS + BAR_W);
  localparam logic [YW+1:0] BAR_H_W = (YW+2)'(BAR_H);

  logic [YW-1:0] y_s;
  logic          busy_s;
  logic [XW+1:0] px_x_s;
  logic [YW+1:0] px_y_s;
  logic [YW+1:0] bar_top_s;
  logic [YW+1:0] bar_bot_s;
  logic          color_d;
  logic          color_q;

  paddle_stepper #(
    .Y_INIT  (Y_INIT),
    .BAR_H   (BAR_H),
    .SCREEN_H(SCREEN_H),
    .STEP    (STEP),
    .YW      (YW)
  ) u_stepper (
    .clk_i      (clk_in),
    .rst_i      (i_rst),
    .cmd_valid_i(clk_en && refreshBar),
    .cmd_y_i    (coordY),
    .frame_end_i(frame_end),
    .y_o        (y_s),
    .busy_o     (busy_s)
  );

  // Paddle hit test for the pixel currently presented.
  always_comb begin
    px_x_s    = {2'b00, o_x};
    px_y_s    = {2'b00, o_y};
    bar_top_s = {2'b00, y_s};
    bar_bot_s = bar_top_s + BAR_H_W;
    if (o_active && (px_x_s >= X_LO) && (px_x_s < X_HI) &&
        (px_y_s >= bar_top_s) && (px_y_s < bar_bot_s)) begin
      color_d = 1'b1;
    end else begin
      color_d = 1'b0;
    end
  end

  // Color register; cleared asynchronously with the rest of the block.
  always_ff @(posedge clk_in or posedge i_rst) begin
    if (i_rst) begin
      color_q <= 1'b0;
    end else begin
      color_q <= color_d;
    end
  end

  assign y_Atual = y_s;
  assign busy    = busy_s;
  assign color   = color_q;

endmodule

// File: tb/tb_print_paddle.sv
// ---------------------------------------------------------------------------
// tb_print_paddle
// Scoreboard bench for print_paddle with default parameters: each stimulus
// step pushes the expected outputs, which are popped and compared once the
// DUT has had its clock edge (or immediately, for asynchronous reset).
// ---------------------------------------------------------------------------
module tb_print_paddle;

  localparam int XW    = 10;
  localparam int YW    = 9;
  localparam int Y_MAX = 390;

  logic          clk_in = 1'b0;
  logic          i_rst;
  logic          clk_en;
  logic          refreshBar;
  logic [YW-1:0] coordY;
  logic          frame_end;
  logic          o_active;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;
  logic [YW-1:0] y_Atual;
  logic          busy;
  logic          color;

  always #5 clk_in = ~clk_in;

  print_paddle dut (
    .clk_in    (clk_in),
    .i_rst     (i_rst),
    .clk_en    (clk_en),
    .refreshBar(refreshBar),
    .coordY    (coordY),
    .frame_end (frame_end),
    .o_active  (o_active),
    .o_x       (o_x),
    .o_y       (o_y),
    .y_Atual   (y_Atual),
    .busy      (busy),
    .color     (color)
  );

  typedef struct {
    string tag;
    int    sel;   // 0 = y_Atual, 1 = busy, 2 = color
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   err_cnt = 0;
  int   chk_cnt = 0;

  // Reference state of the paddle as the specification describes it.
  int y_m;
  int tgt_m;
  int st_m;   // 0 idle, 1 pending, 2 moving

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        0:       obs = {23'd0, y_Atual};
        1:       obs = {31'd0, busy};
        default: obs = {31'd0, color};
      endcase
      check_val(e.tag, obs, e.val);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
    sb_compare();
  endtask

  task automatic model_reset();
    y_m   = 195;
    tgt_m = 195;
    st_m  = 0;
  endtask

  // One clock with optional command and/or frame_end; expected y/busy pushed.
  task automatic tick(input bit cv, input int cy, input bit fe, input string tag);
    int st0;
    int c;
    int d;
    clk_en     = cv;
    refreshBar = cv;
    coordY     = cy[YW-1:0];
    frame_end  = fe;
    st0 = st_m;
    if (fe) begin
      if (st_m == 1) begin
        st_m = 2;
      end else if (st_m == 2) begin
        d = tgt_m - y_m;
        if (d <= 4 && d >= -4) begin
          y_m  = tgt_m;
          st_m = 0;
        end else if (d > 0) begin
          y_m = y_m + 4;
        end else begin
          y_m = y_m - 4;
        end
      end
    end
    if (cv) begin
      c = (cy > Y_MAX) ? Y_MAX : cy;
      if (st0 == 0) begin
        if (c != y_m) begin
          tgt_m = c;
          st_m  = 1;
        end
      end else begin
        tgt_m = c;
      end
    end
    sb_push({tag, "_y"}, 0, y_m);
    sb_push({tag, "_busy"}, 1, (st_m != 0) ? 1 : 0);
    cyc();
    clk_en     = 1'b0;
    refreshBar = 1'b0;
    frame_end  = 1'b0;
  endtask

  task automatic move_until_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (st_m == 0) break;
      tick(1'b0, 0, 1'b1, tag);
    end
  endtask

  task automatic pixel(input bit a, input int x, input int y, input string tag);
    int exp_c;
    o_active = a;
    o_x      = x[XW-1:0];
    o_y      = y[YW-1:0];
    exp_c = (a && x >= 10 && x < 20 && y >= y_m && y < y_m + 90) ? 1 : 0;
    sb_push(tag, 2, exp_c);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst      = 1'b1;
    clk_en     = 1'b0;
    refreshBar = 1'b0;
    coordY     = '0;
    frame_end  = 1'b0;
    o_active   = 1'b0;
    o_x        = '0;
    o_y        = '0;
    model_reset();
    #2;
    sb_push("rst_y", 0, 195);
    sb_push("rst_busy", 1, 0);
    sb_push("rst_color", 2, 0);
    sb_compare();

    // Commands and frame pulses during reset are dropped.
    @(posedge clk_in);
    #1;
    clk_en = 1'b1; refreshBar = 1'b1; coordY = 9'd300; frame_end = 1'b1;
    @(posedge clk_in);
    #1;
    clk_en = 1'b0; refreshBar = 1'b0; frame_end = 1'b0;
    i_rst  = 1'b0;
    sb_push("rst_drop_y", 0, 195);
    sb_push("rst_drop_busy", 1, 0);
    cyc();

    // Move toward 300: pending frame then +4 per frame.
    tick(1'b1, 300, 1'b0, "cmd300");
    tick(1'b0, 0, 1'b1, "mv300_f1");
    tick(1'b0, 0, 1'b1, "mv300_f2");
    tick(1'b0, 0, 1'b1, "mv300_f3");
    // Reverse command coinciding with a frame step: this step is still up.
    tick(1'b1, 100, 1'b1, "rev100");
    move_until_idle("mv100");
    sb_push("at100_y", 0, 100);
    sb_compare();

    // Clamp to bottom of screen and test the last visible row.
    tick(1'b1, 470, 1'b0, "cmd470");
    move_until_idle("mv390");
    sb_push("at390_y", 0, 390);
    sb_push("at390_busy", 1, 0);
    sb_compare();
    pixel(1'b1, 12, 479, "px_bottom_in");
    pixel(1'b1, 12, 480, "px_bottom_out");
    pixel(1'b1, 12, 389, "px_above_top");

    // Back to the reset position via reset, then a short 2-pixel move.
    i_rst = 1'b1;
    #1;
    model_reset();
    sb_push("rst2_y", 0, 195);
    sb_compare();
    cyc();
    i_rst = 1'b0;
    tick(1'b1, 197, 1'b0, "cmd197");
    tick(1'b0, 0, 1'b1, "mv197_f1");
    tick(1'b0, 0, 1'b1, "mv197_f2");
    tick(1'b1, 197, 1'b0, "cmd197_again");
    tick(1'b1, 195, 1'b0, "cmd195");
    move_until_idle("mv195");

    // Raster edges with the paddle at 195.
    pixel(1'b1, 19, 200, "px_x19");
    pixel(1'b1, 20, 200, "px_x20");
    pixel(1'b1, 10, 200, "px_x10");
    pixel(1'b1, 9, 200, "px_x9");
    pixel(1'b1, 15, 284, "px_y284");
    pixel(1'b1, 15, 285, "px_y285");
    pixel(1'b1, 15, 195, "px_y195");
    pixel(1'b1, 15, 194, "px_y194");
    pixel(1'b0, 15, 200, "px_inactive");

    // Reset mid-move at 231 clears outputs without a clock edge.
    tick(1'b1, 300, 1'b0, "cmd300b");
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 0, 1'b1, "mv231");
    end
    sb_push("at231_y", 0, 231);
    sb_compare();
    pixel(1'b1, 12, 240, "px_before_rst");
    #3;
    i_rst = 1'b1;
    #1;
    model_reset();
    sb_push("arst_y", 0, 195);
    sb_push("arst_busy", 1, 0);
    sb_push("arst_color", 2, 0);
    sb_compare();
    o_active = 1'b0;
    cyc();
    i_rst = 1'b0;
    tick(1'b0, 0, 1'b1, "post_rst");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
